// File: rtl/onchip_mem_copy_dma.sv
// Word copy engine driving the s1 port of the 2048x16 on-chip RAM; one word per three cycles.
// Optional macro DMA_IRQ_EN adds an interrupt-enable CSR bit and a registered irq output.
module onchip_mem_copy_dma #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_write,
    input  logic              s_read,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic [1:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
`ifdef DMA_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mcs_q, mcs_d;
    logic              mwr_q, mwr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;

    logic              csr_wr;
    logic              csr_rd;
    logic              idle;
    logic              ie_rd;
    logic [31:0]       status;
    logic              unused_wdata;

    assign csr_wr       = s_chipselect & s_write;
    assign csr_rd       = s_chipselect & s_read;
    assign idle         = (state_q == IDLE);
    assign status       = {28'd0, ie_rd, err_q, done_q, busy_q};
    assign unused_wdata = ^s_writedata[31:LEN_W];

    assign s_readdata   = rdata_q;
    assign m_address    = maddr_q;
    assign m_byteenable = 2'b11;
    assign m_chipselect = mcs_q;
    assign m_write      = mwr_q;
    assign m_writedata  = mwdata_q;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;

        if (csr_wr) begin
            case (s_address)
                2'd0: if (idle) src_d = s_writedata[ADDR_W-1:0];
                2'd1: if (idle) dst_d = s_writedata[ADDR_W-1:0];
                2'd2: if (idle) len_d = s_writedata[LEN_W-1:0];
                default: begin
                    // CLR takes effect before START is looked at
                    if (s_writedata[1]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                    if (s_writedata[0] && idle) begin
                        rd_ptr_d = src_q;
                        wr_ptr_d = dst_q;
                        rem_d    = len_q;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        if (len_q > MAX_LEN) begin
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end else if (len_q == '0) begin
                            state_d = FINISH;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
            endcase
        end

        case (state_q)
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                mwdata_d = m_readdata;
                state_d  = WRITE;
            end
            WRITE: begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                rem_d    = rem_q - LEN_W'(1);
                state_d  = (rem_q == LEN_W'(1)) ? FINISH : ISSUE;
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase

        // RAM strobes are decoded from the next state so they leave a flop
        mcs_d = (state_d == ISSUE) || (state_d == WRITE);
        mwr_d = (state_d == WRITE);
        if (state_d == ISSUE) begin
            maddr_d = rd_ptr_d;
        end else if (state_d == WRITE) begin
            maddr_d = wr_ptr_d;
        end

        if (csr_rd) begin
            case (s_address)
                2'd0:    rdata_d = {{(32-ADDR_W){1'b0}}, src_q};
                2'd1:    rdata_d = {{(32-ADDR_W){1'b0}}, dst_q};
                2'd2:    rdata_d = {{(32-LEN_W){1'b0}}, len_q};
                default: rdata_d = status;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mcs_q    <= 1'b0;
            mwr_q    <= 1'b0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            maddr_q  <= maddr_d;
            mcs_q    <= mcs_d;
            mwr_q    <= mwr_d;
            mwdata_q <= mwdata_d;
        end
    end

`ifdef DMA_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    assign ie_rd = ie_q;
    assign irq   = irq_q;
    assign irq_d = ie_q & done_q;

    always_comb begin
        ie_d = ie_q;
        if (csr_wr && s_address == 2'd3) begin
            ie_d = s_writedata[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
`else
    assign ie_rd = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_mem_copy_dma.sv
// Bench for onchip_mem_copy_dma: behavioural RAM, array reference model, vector table and corner sequences.
module tb_onchip_mem_copy_dma;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write;
    logic        s_read;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [10:0] m_address;
    logic [1:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
`ifdef DMA_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    onchip_mem_copy_dma dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write      (s_write),
        .s_read       (s_read),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata)
`ifdef DMA_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    // RAM: registered address, unregistered q, plus a backdoor load port
    logic [15:0] mem [DEPTH];
    logic [10:0] ram_addr_q = '0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_cs = 0;
    logic        bd_en;
    logic [10:0] bd_addr;
    logic [15:0] bd_data;

    assign m_readdata = mem[ram_addr_q];

    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        if (m_chipselect) begin
            ram_addr_q <= m_address;
            n_cs       <= n_cs + 1;
            if (m_write) begin
                if (m_byteenable[0]) mem[m_address][7:0]  <= m_writedata[7:0];
                if (m_byteenable[1]) mem[m_address][15:8] <= m_writedata[15:8];
                n_wr <= n_wr + 1;
            end else begin
                n_rd <= n_rd + 1;
            end
        end
    end

    logic [15:0] model [DEPTH];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        model[a] = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(negedge clk);
        s_chipselect = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic model_copy(input logic [10:0] src, input logic [10:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            model[(int'(dst) + i) % DEPTH] = model[(int'(src) + i) % DEPTH];
        end
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== model[i]) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] st;
        int k = 0;
        st = '0;
        while (st[1] !== 1'b1 && k < 400) begin
            csr_rd(2'd3, st);
            k++;
        end
        check({name, " done"}, 32'(st[1]), 32'd1);
    endtask

    // START is written with a status read held on, so every cycle returns status one cycle late
    task automatic run_copy(input string name, input logic [10:0] src, input logic [10:0] dst,
                            input logic [11:0] len, input int exp_cyc, input logic [31:0] exp_stat);
        int rd0, wr0, cs0, j, n_exp;
        bit got;
        logic [31:0] stat;
        csr_wr(2'd0, 32'(src));
        csr_wr(2'd1, 32'(dst));
        csr_wr(2'd2, 32'(len));
        n_exp = (int'(len) > DEPTH) ? 0 : int'(len);
        model_copy(src, dst, n_exp);
        rd0 = n_rd; wr0 = n_wr; cs0 = n_cs;
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_read = 1'b1; s_address = 2'd3; s_writedata = 32'h1;
        @(negedge clk);
        s_write = 1'b0;
        j = 0; got = 1'b0;
        while (!got && j < 8000) begin
            @(negedge clk);
            j++;
            if (s_readdata[1]) got = 1'b1;
        end
        stat = s_readdata;
        s_chipselect = 1'b0; s_read = 1'b0;
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " cycles"}, 32'(j - 1), 32'(exp_cyc));
        check({name, " status"}, stat, exp_stat);
        check({name, " reads"}, 32'(n_rd - rd0), 32'(n_exp));
        check({name, " writes"}, 32'(n_wr - wr0), 32'(n_exp));
        check({name, " chipselects"}, 32'(n_cs - cs0), 32'(2 * n_exp));
        mem_check({name, " mem"});
    endtask

    typedef struct {
        logic [10:0] src;
        logic [10:0] dst;
        logic [11:0] len;
        int          exp_cyc;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rd;
        int          wr0, cs0;
        logic [10:0] rs, rdst;
        logic [11:0] rl;

        vecs[0] = '{11'd0,    11'd100,  12'd4,    13,   32'h2};
        vecs[1] = '{11'd5,    11'd900,  12'd0,    1,    32'h2};
        vecs[2] = '{11'd5,    11'd900,  12'd3000, 0,    32'h6};
        vecs[3] = '{11'd2047, 11'd10,   12'd2,    7,    32'h2};
        vecs[4] = '{11'd200,  11'd201,  12'd5,    16,   32'h2};
        vecs[5] = '{11'd0,    11'd1024, 12'd2048, 6145, 32'h2};
        vecs[6] = '{11'd7,    11'd8,    12'd2049, 0,    32'h6};
        vecs[7] = '{11'd1500, 11'd1400, 12'd1,    4,    32'h2};

        reset_n = 1'b0;
        s_address = '0; s_chipselect = 1'b0; s_write = 1'b0; s_read = 1'b0; s_writedata = '0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clk);
        check("reset m_address", 32'(m_address), 32'd0);
        check("reset m_byteenable", 32'(m_byteenable), 32'd3);
        check("reset m_chipselect", 32'(m_chipselect), 32'd0);
        check("reset m_write", 32'(m_write), 32'd0);
        check("reset m_writedata", 32'(m_writedata), 32'd0);
        check("reset s_readdata", s_readdata, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bd_en = 1'b1; bd_addr = 11'(i); bd_data = 16'($urandom);
            model[i] = bd_data;
        end
        @(negedge clk);
        bd_en = 1'b0;
        poke(11'd0, 16'h1111);
        poke(11'd1, 16'h2222);
        poke(11'd2, 16'h3333);
        poke(11'd3, 16'h4444);
        poke(11'd2047, 16'hABCD);

        csr_rd(2'd3, rd);
        check("idle status", rd, 32'd0);
        csr_wr(2'd0, 32'hFFFF_FFFF);
        csr_rd(2'd0, rd);
        check("src unused bits", rd, 32'h7FF);
        csr_wr(2'd2, 32'hFFFF_FFFF);
        csr_rd(2'd2, rd);
        check("len unused bits", rd, 32'hFFF);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) poke(11'd0, 16'h1234);
            run_copy($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len,
                     vecs[i].exp_cyc, vecs[i].exp_stat);
            if (i == 0) begin
                check("preload copy 100", 32'(mem[100]), 32'h1111);
                check("preload copy 103", 32'(mem[103]), 32'h4444);
            end
            if (i == 3) begin
                check("wrap copy 10", 32'(mem[10]), 32'hABCD);
                check("wrap copy 11", 32'(mem[11]), 32'h1234);
            end
        end

        for (int r = 0; r < 4; r++) begin
            rs   = 11'($urandom_range(0, DEPTH - 1));
            rdst = 11'($urandom_range(0, DEPTH - 1));
            rl   = 12'($urandom_range(1, 40));
            run_copy($sformatf("rand%0d", r), rs, rdst, rl, 3 * int'(rl) + 1, 32'h2);
        end

        csr_wr(2'd3, 32'h2);
        csr_rd(2'd3, rd);
        check("clr status", rd, 32'd0);

        // Register writes and a second START while busy must be ignored
        csr_wr(2'd0, 32'd300);
        csr_wr(2'd1, 32'd500);
        csr_wr(2'd2, 32'd16);
        model_copy(11'd300, 11'd500, 16);
        wr0 = n_wr;
        csr_wr(2'd3, 32'h1);
        csr_rd(2'd3, rd);
        check("busy status", rd, 32'h1);
        csr_wr(2'd2, 32'd5);
        csr_wr(2'd0, 32'd7);
        csr_wr(2'd3, 32'h1);
        wait_done("busy-ignore");
        csr_rd(2'd2, rd);
        check("busy-ignore len", rd, 32'd16);
        csr_rd(2'd0, rd);
        check("busy-ignore src", rd, 32'd300);
        check("busy-ignore writes", 32'(n_wr - wr0), 32'd16);
        mem_check("busy-ignore mem");

        // Reset after the fifth word has been written
        csr_wr(2'd0, 32'd600);
        csr_wr(2'd1, 32'd700);
        csr_wr(2'd2, 32'd16);
        model_copy(11'd600, 11'd700, 5);
        wr0 = n_wr;
        csr_wr(2'd3, 32'h1);
        for (int k = 0; k < 200 && (n_wr - wr0) < 5; k++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort m_address", 32'(m_address), 32'd0);
        check("abort m_byteenable", 32'(m_byteenable), 32'd3);
        check("abort m_chipselect", 32'(m_chipselect), 32'd0);
        check("abort m_write", 32'(m_write), 32'd0);
        check("abort m_writedata", 32'(m_writedata), 32'd0);
        reset_n = 1'b1;
        cs0 = n_cs;
        repeat (10) @(negedge clk);
        check("abort no access", 32'(n_cs - cs0), 32'd0);
        check("abort writes", 32'(n_wr - wr0), 32'd5);
        csr_rd(2'd3, rd);
        check("abort status", rd, 32'd0);
        csr_rd(2'd0, rd);
        check("abort src cleared", rd, 32'd0);
        mem_check("abort mem");

`ifdef DMA_IRQ_EN
        csr_wr(2'd3, 32'h2);
        csr_wr(2'd3, 32'h4);
        csr_rd(2'd3, rd);
        check("ie readback", rd, 32'h8);
        csr_wr(2'd0, 32'd40);
        csr_wr(2'd1, 32'd41);
        csr_wr(2'd2, 32'd1);
        model_copy(11'd40, 11'd41, 1);
        csr_wr(2'd3, 32'h5);
        repeat (4) @(negedge clk);
        check("irq before done", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq after done", 32'(irq), 32'd1);
        csr_wr(2'd3, 32'h6);
        check("irq at clr", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq after clr", 32'(irq), 32'd0);
        csr_wr(2'd3, 32'h0);
        csr_wr(2'd3, 32'h1);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (irq) seen = 1'b1;
            end
            check("irq with ie off", 32'(seen), 32'd0);
        end
        csr_rd(2'd3, rd);
        check("ie off status", rd, 32'h2);
`else
        csr_wr(2'd3, 32'h4);
        csr_rd(2'd3, rd);
        check("ie ignored", rd, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
